// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic [1:0] ERR_PARITY   = 2'd0;
  localparam logic [1:0] ERR_STOP     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchroniser plus run-length glitch filter for one asynchronous PS/2 pin.
// The filtered level changes only after FILTER_LEN consecutive synchronised
// samples disagree with it; rise/fall pulse in the first cycle of the new level.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sample;

  assign sample  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

  // Flop chain; resets to the idle-high pin level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  // Count disagreeing samples; flip the level once the run is long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sample != level_q) begin
        if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
          level_q <= sample;
          cnt_q   <= '0;
          rise_q  <= sample;
          fall_q  <= ~sample;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: conditioned pins, frame FSM with
// start/parity/stop checks and timeout, show-ahead output FIFO, coded errors.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_strb,
  output logic [1:0]           err_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic clk_level, clk_rise, fall;
  logic d_level, d_rise, d_fall;
  logic unused_w;

  ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .pin_i(ps2_clk),
    .level_o(clk_level), .rise_o(clk_rise), .fall_o(fall)
  );

  ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(1)) u_data_filt (
    .clk(clk), .rst(rst), .pin_i(ps2_data),
    .level_o(d_level), .rise_o(d_rise), .fall_o(d_fall)
  );

  assign unused_w = ^{clk_level, clk_rise, d_rise, d_fall};

  state_e               state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [2:0]           bitcnt_q;
  logic                 par_acc_q;
  logic                 par_q;
  logic [TMO_W-1:0]     tmo_q;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;

  logic full, frame_ok, pop, push, overflow;

  // Frame completion and FIFO handshake decode.
  assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign frame_ok  = fall && (state_q == ST_STOP) && d_level && (par_acc_q ^ par_q);
  assign pop       = out_valid && out_ready;
  assign push      = frame_ok && (!full || pop);
  assign overflow  = frame_ok && full && !pop;

  // Frame FSM, timeout counter and registered error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      tmo_q    <= '0;
      err_strb <= 1'b0;
      err_code <= ERR_PARITY;
    end else begin
      err_strb <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (fall && !d_level) begin
            state_q   <= ST_DATA;
            bitcnt_q  <= '0;
            par_acc_q <= 1'b0;
          end
        end
        default: begin
          if (fall) begin
            tmo_q <= '0;
            case (state_q)
              ST_DATA: begin
                shreg_q   <= {d_level, shreg_q[DATA_BITS-1:1]};
                par_acc_q <= par_acc_q ^ d_level;
                bitcnt_q  <= bitcnt_q + 1'b1;
                if (bitcnt_q == 3'(DATA_BITS - 1)) state_q <= ST_PARITY;
              end
              ST_PARITY: begin
                par_q   <= d_level;
                state_q <= ST_STOP;
              end
              default: begin
                state_q <= ST_IDLE;
                if (!d_level) begin
                  err_strb <= 1'b1;
                  err_code <= ERR_STOP;
                end else if (!(par_acc_q ^ par_q)) begin
                  err_strb <= 1'b1;
                  err_code <= ERR_PARITY;
                end else if (overflow) begin
                  err_strb <= 1'b1;
                  err_code <= ERR_OVERFLOW;
                end
              end
            endcase
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 2)) begin
            // The counter reaches TIMEOUT_CYCLES-1 at this edge: abort.
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            err_strb <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset since out_data is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shreg_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: bytes and error codes are queued
// when frames are driven and checked as the receiver produces them.
module tb_ps2_frame_receiver;
  import ps2_pkg::*;

  localparam int T   = 2000;
  localparam int H   = 40;
  localparam int LAT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       err_strb;
  logic [1:0] err_code;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cyc = -1;
  int last_fall;
  logic [7:0] exp_q[$];
  logic [1:0] err_q[$];

  ps2_frame_receiver dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_strb(err_strb), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", exp_q.size(), 1);
        else                   chk("beat_data", out_data, exp_q.pop_front());
      end
      if (err_strb) begin
        err_cyc = cyc;
        if (err_q.size() == 0) chk("err_unexpected", err_q.size(), 1);
        else                   chk("err_code", err_code, err_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive the first nbits of an 11-bit device frame.
  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_v,
                            input int nbits, input bit glitch, input bit pop_at_stop,
                            output int fall_cyc);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    fr[9]   = ~(^d) ^ par_bad;
    fr[10]  = stop_v;
    fall_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch && i == 4) begin
        tick(H/2); ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1; tick(H - H/2 - 2);
      end else begin
        tick(H);
      end
      ps2_clk = 1'b0;
      fall_cyc = cyc;
      if (pop_at_stop && i == 10) begin
        tick(LAT); out_ready = 1'b1; tick(1); out_ready = 1'b0; tick(H - LAT - 1);
      end else begin
        tick(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(H);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    // Reset state
    rst = 1'b1;
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_strb", err_strb, 0);
    chk("rst_err_code", err_code, 0);
    rst = 1'b0;
    tick(5);

    // 1: good frame, single beat
    valid_cnt = 0;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 1, 11, 0, 0, f);
    tick(20);
    chk("t1_valid_cycles", valid_cnt, 1);

    // 2: parity error, then good frame
    valid_cnt = 0;
    err_q.push_back(ERR_PARITY);
    send_frame(8'h1C, 1, 1, 11, 0, 0, f);
    tick(20);
    chk("t2_no_valid", valid_cnt, 0);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 0, 1, 11, 0, 0, f);
    tick(20);

    // 3: stop-bit error, then good frame
    err_q.push_back(ERR_STOP);
    send_frame(8'h29, 0, 0, 11, 0, 0, f);
    tick(20);
    exp_q.push_back(8'h29);
    send_frame(8'h29, 0, 1, 11, 0, 0, f);
    tick(20);

    // 4: timeout after start + 5 data bits
    err_cyc = -1;
    err_q.push_back(ERR_TIMEOUT);
    send_frame(8'h15, 0, 1, 6, 0, 0, last_fall);
    for (int k = 0; k < T + 100 && err_cyc < 0; k++) tick(1);
    chk("t4_timeout_latency", err_cyc - last_fall, LAT + T);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 1, 11, 0, 0, f);
    tick(20);

    // 5: fill, overflow, simultaneous push/pop while full, drain
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 0, 1, 11, 0, 0, f);
    end
    chk("t5_full_valid", out_valid, 1);
    chk("t5_head", out_data, 8'h01);
    err_q.push_back(ERR_OVERFLOW);
    send_frame(8'h05, 0, 1, 11, 0, 0, f);
    tick(20);
    exp_q.push_back(8'h06);
    send_frame(8'h06, 0, 1, 11, 0, 1, f);
    tick(20);
    chk("t5_head_after_swap", out_data, 8'h02);
    out_ready = 1'b1;
    tick(10);
    chk("t5_drained", out_valid, 0);

    // 6a: clock glitch mid-frame
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, 1, 11, 1, 0, f);
    tick(20);

    // 6b: reset mid-frame with two bytes queued
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0, 1, 11, 0, 0, f);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 0, 1, 11, 0, 0, f);
    chk("t6_queued_valid", out_valid, 1);
    send_frame(8'h77, 0, 1, 5, 0, 0, f);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_err", err_strb, 0);
    tick(5);
    out_ready = 1'b1;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 0, 1, 11, 0, 0, f);
    tick(T + 50);

    chk("beats_left", exp_q.size(), 0);
    chk("errs_left", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
